// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin drain of four input FIFOs into four destination-addressed output FIFOs
module fifo_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             enable,
  input  logic [3:0]       in_empty,
  input  logic [23:0]      in_data,
  input  logic [3:0]       out_al_full,
  input  logic [3:0]       out_full,
  output logic [3:0]       in_rd,
  output logic [3:0]       out_wr,
  output logic [5:0]       out_data,
  output logic             err_drop,
  output logic             idle,
  output logic [CNT_W-1:0] fwd_count
);
  typedef enum logic [1:0] {INIT, IDLE, RUN, HOLD} state_t;
  state_t     state;
  logic [1:0] rr_ptr, gnt_idx, p1, p2, p3, s1_idx, dest;
  logic [3:0] req;
  logic [5:0] word;
  logic       s1_v, gnt, deliver;
  assign req     = ~in_empty;
  assign p1      = rr_ptr + 2'd1;
  assign p2      = rr_ptr + 2'd2;
  assign p3      = rr_ptr + 2'd3;
  assign gnt_idx = req[p1] ? p1 : req[p2] ? p2 : req[p3] ? p3 : rr_ptr;
  assign gnt     = state == RUN && enable && |req && ~|out_al_full;
  assign in_rd   = gnt ? 4'b0001 << gnt_idx : 4'b0000;
  assign word    = in_data[6*s1_idx +: 6];
  assign dest    = word[5:4];
  assign deliver = s1_v && !out_full[dest];
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= INIT;
      rr_ptr    <= 2'd3;
      s1_v      <= 1'b0;
      s1_idx    <= 2'd0;
      out_wr    <= 4'b0000;
      out_data  <= 6'd0;
      err_drop  <= 1'b0;
      idle      <= 1'b0;
      fwd_count <= '0;
    end else begin
      state     <= state == INIT ? IDLE : (!enable || ~|req) ? IDLE : |out_al_full ? HOLD : RUN;
      rr_ptr    <= gnt ? gnt_idx : rr_ptr;
      s1_v      <= gnt;
      s1_idx    <= gnt_idx;
      out_wr    <= deliver ? 4'b0001 << dest : 4'b0000;
      out_data  <= s1_v ? word : out_data;
      err_drop  <= s1_v && out_full[dest];
      fwd_count <= deliver ? fwd_count + CNT_W'(1) : fwd_count;
      idle      <= state == IDLE && !s1_v && ~|out_wr;
    end
  end
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: cycle-by-cycle directed vectors plus enable-drop and idle sequences
module tb_fifo_arbiter;
  logic        clk = 1'b0;
  logic        RESET, enable;
  logic [3:0]  in_empty, out_al_full, out_full, in_rd, out_wr;
  logic [23:0] in_data;
  logic [5:0]  out_data;
  logic        err_drop, idle;
  logic [7:0]  fwd_count;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    logic        rst, en;
    logic [3:0]  emp;
    logic [23:0] dat;
    logic [3:0]  af, full, rd, wr;
    logic [5:0]  od;
    logic        err, idl;
    logic [7:0]  cnt;
  } vec_t;
  localparam logic [23:0] RR = {6'h33, 6'h22, 6'h11, 6'h00};
  localparam logic [23:0] S2 = {6'h00, 6'h25, 12'h000};
  localparam logic [23:0] D2 = {6'h00, 6'h2A, 12'h000};
  vec_t tbl[48];
  fifo_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .RESET(RESET), .enable(enable), .in_empty(in_empty), .in_data(in_data),
    .out_al_full(out_al_full), .out_full(out_full), .in_rd(in_rd), .out_wr(out_wr),
    .out_data(out_data), .err_drop(err_drop), .idle(idle), .fwd_count(fwd_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst, logic en, logic [3:0] emp, logic [23:0] dat, logic [3:0] af,
                              logic [3:0] full, logic [3:0] rd, logic [3:0] wr, logic [5:0] od,
                              logic err, logic idl, logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.emp = emp; v.dat = dat; v.af = af; v.full = full;
    v.rd = rd; v.wr = wr; v.od = od; v.err = err; v.idl = idl; v.cnt = cnt;
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  initial begin
    int pushes;
    int k;
    tbl[0]  = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 0);
    tbl[2]  = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 0);
    tbl[3]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 0);
    tbl[4]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h1, 4'h0, 6'h00, 0, 1, 0);
    tbl[5]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h2, 4'h0, 6'h00, 0, 0, 0);
    tbl[6]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h4, 4'h1, 6'h00, 0, 0, 1);
    tbl[7]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h8, 4'h2, 6'h11, 0, 0, 2);
    tbl[8]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h1, 4'h4, 6'h22, 0, 0, 3);
    tbl[9]  = mk(0, 1, 4'h0, RR, 0, 0, 4'h2, 4'h8, 6'h33, 0, 0, 4);
    tbl[10] = mk(0, 1, 4'h0, RR, 0, 0, 4'h4, 4'h1, 6'h00, 0, 0, 5);
    tbl[11] = mk(0, 1, 4'h0, RR, 0, 0, 4'h8, 4'h2, 6'h11, 0, 0, 6);
    tbl[12] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h4, 6'h22, 0, 0, 7);
    tbl[13] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h8, 6'h33, 0, 0, 8);
    tbl[14] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 8);
    tbl[15] = mk(0, 1, 4'hB, S2, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 8);
    tbl[16] = mk(0, 1, 4'hB, S2, 0, 0, 4'h4, 4'h0, 6'h00, 0, 1, 8);
    tbl[17] = mk(0, 1, 4'hB, S2, 0, 0, 4'h4, 4'h0, 6'h00, 0, 0, 8);
    tbl[18] = mk(0, 1, 4'hB, S2, 0, 0, 4'h4, 4'h4, 6'h25, 0, 0, 9);
    tbl[19] = mk(0, 1, 4'hF, S2, 0, 0, 4'h0, 4'h4, 6'h25, 0, 0, 10);
    tbl[20] = mk(0, 1, 4'hF, S2, 0, 0, 4'h0, 4'h4, 6'h25, 0, 0, 11);
    tbl[21] = mk(0, 1, 4'hF, S2, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 11);
    tbl[22] = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 11);
    tbl[23] = mk(0, 1, 4'h0, RR, 0, 0, 4'h8, 4'h0, 6'h00, 0, 1, 11);
    tbl[24] = mk(0, 1, 4'h0, RR, 0, 0, 4'h1, 4'h0, 6'h00, 0, 0, 11);
    tbl[25] = mk(0, 1, 4'h0, RR, 2, 0, 4'h0, 4'h8, 6'h33, 0, 0, 12);
    tbl[26] = mk(0, 1, 4'h0, RR, 2, 0, 4'h0, 4'h1, 6'h00, 0, 0, 13);
    tbl[27] = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 13);
    tbl[28] = mk(0, 1, 4'h0, RR, 0, 0, 4'h2, 4'h0, 6'h00, 0, 0, 13);
    tbl[29] = mk(0, 1, 4'h0, RR, 0, 0, 4'h4, 4'h0, 6'h00, 0, 0, 13);
    tbl[30] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h2, 6'h11, 0, 0, 14);
    tbl[31] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h4, 6'h22, 0, 0, 15);
    tbl[32] = mk(0, 1, 4'hF, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 15);
    tbl[33] = mk(0, 1, 4'hB, D2, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 15);
    tbl[34] = mk(0, 1, 4'hB, D2, 0, 0, 4'h4, 4'h0, 6'h00, 0, 1, 15);
    tbl[35] = mk(0, 1, 4'hF, D2, 0, 4, 4'h0, 4'h0, 6'h00, 0, 0, 15);
    tbl[36] = mk(0, 1, 4'hF, D2, 0, 0, 4'h0, 4'h0, 6'h2A, 1, 0, 15);
    tbl[37] = mk(0, 1, 4'hF, D2, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 15);
    tbl[38] = mk(0, 0, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 15);
    tbl[39] = mk(0, 0, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 15);
    tbl[40] = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 1, 15);
    tbl[41] = mk(0, 1, 4'h0, RR, 0, 0, 4'h8, 4'h0, 6'h00, 0, 1, 15);
    tbl[42] = mk(1, 1, 4'h0, RR, 0, 0, 4'h1, 4'h0, 6'h00, 0, 0, 15);
    tbl[43] = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 0);
    tbl[44] = mk(0, 1, 4'h0, RR, 0, 0, 4'h0, 4'h0, 6'h00, 0, 0, 0);
    tbl[45] = mk(0, 1, 4'h0, RR, 0, 0, 4'h1, 4'h0, 6'h00, 0, 1, 0);
    tbl[46] = mk(0, 1, 4'h0, RR, 0, 0, 4'h2, 4'h0, 6'h00, 0, 0, 0);
    tbl[47] = mk(0, 1, 4'h0, RR, 0, 0, 4'h4, 4'h1, 6'h00, 0, 0, 1);
    RESET = 1'b1; enable = 1'b1; in_empty = 4'hF; in_data = '0; out_al_full = '0; out_full = '0;
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      RESET = tbl[i].rst; enable = tbl[i].en; in_empty = tbl[i].emp; in_data = tbl[i].dat;
      out_al_full = tbl[i].af; out_full = tbl[i].full;
      #1;
      chk("in_rd", i, 32'(in_rd), 32'(tbl[i].rd));
      chk("out_wr", i, 32'(out_wr), 32'(tbl[i].wr));
      chk("err_drop", i, 32'(err_drop), 32'(tbl[i].err));
      chk("idle", i, 32'(idle), 32'(tbl[i].idl));
      chk("fwd_count", i, 32'(fwd_count), 32'(tbl[i].cnt));
      if (tbl[i].wr != 4'h0 || tbl[i].err) chk("out_data", i, 32'(out_data), 32'(tbl[i].od));
    end
    @(negedge clk);
    enable = 1'b0;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rd_after_disable", i, 32'(in_rd), 32'h0);
      if (|out_wr) pushes++;
    end
    chk("pushes_after_disable", 0, 32'(pushes), 32'd2);
    chk("count_after_disable", 0, 32'(fwd_count), 32'd3);
    in_empty = 4'hF;
    k = 0;
    while (!idle && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("idle_within_budget", k, 32'(idle), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
